surf_event_arbiter: RTL and testbench
=====================================

Name: surf_event_arbiter

Overview:
Packet-level round-robin merger of the seven per-SURF 8-bit AXI4-Stream event outputs (sysclk domain, with tlast) into one stream for the TURF uplink. It sits downstream of the SURF interface instances and tags each packet with its source index. A source that stalls mid-packet gets a terminating abort byte and is quarantined until software clears it.

Parameters:
NSURF, 7, number of input streams (index width 3).
TIMEOUT, 1024, source-idle cycles mid-packet before abort (1..65535).
ABORT_BYTE, 8'hFF, data byte emitted with tlast on abort.

Ports:
sysclk_i  in  1  sole clock.
sysrst_n_i  in  1  reset, asynchronous, active-low.
enable_i  in  7  per-source arbitration enable, sampled only at grant.
s_tdata  in  56  source data; source i occupies bits [8*i +: 8].
s_tvalid  in  7  source valid.
s_tlast  in  7  source last.
s_tready  out  7  source ready.
m_tdata  out  8  merged data.
m_tvalid  out  1  merged valid.
m_tlast  out  1  merged last.
m_tuser  out  3  source index of the current beat.
m_tready  in  1  merged ready.
timeout_o  out  7  sticky per-source abort/quarantine flags.
timeout_clr_i  in  7  per-bit clear of timeout_o (single-cycle pulse).
busy_o  out  1  high in PASS or ABORT.
pkt_count_o  out  16  count of completed non-aborted packets; wraps.

Behaviour:
- Reset (async assert, sync deassert handled upstream) drives: state IDLE; sel=0; last_grant=NSURF-1; m_tvalid=0; m_tlast=0; m_tdata=0; m_tuser=0; s_tready=0; timeout_o=0; pkt_count_o=0; idle counter=0; busy_o=0.
- Reset mid-packet: the output drops tvalid immediately. Downstream framing loss is accepted.
- States: IDLE, PASS, ABORT.
- IDLE:
  - cand = s_tvalid & enable_i & ~timeout_o.
  - If cand≠0, sel ← first set bit searching upward from last_grant+1, wrapping modulo NSURF. last_grant ← sel. Go to PASS.
  - In IDLE, m_tvalid=0.
  - Grant costs exactly one cycle, so there is one idle cycle between packets.
- PASS (combinational pass-through of the selected source):
  - m_tdata=s_tdata[sel], m_tvalid=s_tvalid[sel], m_tlast=s_tlast[sel], m_tuser=sel, s_tready[sel]=m_tready.
  - All other non-quarantined sources have s_tready=0.
  - A beat with m_tvalid&m_tready&m_tlast returns to IDLE and increments pkt_count_o.
  - Deasserting enable_i mid-packet does not interrupt the packet.
- Idle counter:
  - Resets to 0 on entry to PASS and on every accepted beat.
  - Increments each PASS cycle in which s_tvalid[sel]=0.
  - Cycles where the source is valid but m_tready=0 do not count; this is downstream backpressure, not a source stall.
  - When the counter reaches TIMEOUT-1 while s_tvalid[sel]=0, the next state is ABORT and timeout_o[sel] is set.
- ABORT:
  - m_tvalid=1, m_tdata=ABORT_BYTE, m_tlast=1, m_tuser=sel, s_tready[sel]=0.
  - Holds until m_tready, then goes to IDLE. pkt_count_o does not increment.
- Quarantine: while timeout_o[i]=1 and source i is not sel in PASS, s_tready[i]=1. Stale bytes are sunk so a dead source cannot hang the arbiter.
- timeout_clr_i[i] clears timeout_o[i] on the next edge. If clear and set hit the same bit in the same cycle, set wins.
- Boundaries:
  - A single-beat packet (tlast on the first beat) is legal.
  - Only one candidate: it is re-granted every packet.
  - Every enable bit 0: the arbiter stays in IDLE.
  - sel's tlast on the same cycle the idle counter hits the limit: cannot occur, because tlast requires tvalid and tvalid resets the count path.
- pkt_count_o wraps 16'hFFFF→0.

Decomposition:
- Package surfturf_arb_pkg holds:
  - NSURF_DEFAULT.
  - the state typedef enum {IDLE, PASS, ABORT}.
  - the ABORT_BYTE default.
  - the index width localparam (3).
- Sub-module surf_rr_pick is natural.
  - Inputs: request vector and last_grant. Outputs: next index and valid.
  - Purely combinational, rotate / priority-encode / unrotate.

Test Plan:
- All 7 sources valid with 4-byte packets, m_tready=1 → m_tuser sequence 0,1,2,3,4,5,6,0; one idle cycle between packets; pkt_count_o=8 after 8 packets.
- Sources 2 and 5 only, last_grant=6 after reset → grant order 2,5,2,5. enable_i[5] dropped mid-packet of 5 → that packet completes, and the next grants are 2 only.
- m_tready toggling 1/0 every cycle with source 3 continuously valid, TIMEOUT=16 → no abort; all bytes delivered in order with correct tlast.
- Source 4 sends 2 bytes then stalls, TIMEOUT=16 → after 16 idle cycles one beat m_tdata=8'hFF, m_tlast=1, m_tuser=4; timeout_o=7'b0010000; s_tready[4] then stays 1; pkt_count_o unchanged.
- With timeout_o[4] set, source 4 valid and other sources valid → source 4 never granted. Pulse timeout_clr_i[4] → source 4 granted in the next rotation.
- Assert sysrst_n_i low mid-packet (PASS on source 1) → m_tvalid=0 asynchronously and all outputs at reset values; after release the first grant goes to the lowest valid enabled source.

Source files
------------

// File: rtl/surfturf_arb_pkg.sv
// Shared types and defaults for the SURF event arbiter slice.
package surfturf_arb_pkg;

    localparam int         NSURF_DEFAULT      = 7;
    localparam int         IDX_W              = 3;
    localparam logic [7:0] ABORT_BYTE_DEFAULT = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        PASS,
        ABORT
    } arb_state_e;

endpackage

// File: rtl/surf_rr_pick.sv
// Combinational round-robin picker: first request searching upward from
// last_grant+1, wrapping modulo NSURF.
module surf_rr_pick
    import surfturf_arb_pkg::*;
#(
    parameter int NSURF = NSURF_DEFAULT
) (
    input  logic [NSURF-1:0] req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [IDX_W-1:0] pick,
    output logic             pick_vld
);

    logic [NSURF-1:0] rot;
    int               base;

    // rotate so that last_grant+1 sits at bit 0, priority-encode, unrotate
    always_comb begin
        base     = (int'(last_grant) + 1) % NSURF;
        rot      = '0;
        pick     = '0;
        pick_vld = 1'b0;
        for (int k = 0; k < NSURF; k++) begin
            rot[k] = req[(base + k) % NSURF];
        end
        for (int k = NSURF - 1; k >= 0; k--) begin
            if (rot[k]) begin
                pick     = IDX_W'((base + k) % NSURF);
                pick_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/surf_event_arbiter.sv
// Packet-level round-robin merger of the per-SURF event streams, tagging each
// beat with its source index and aborting/quarantining sources that stall.
module surf_event_arbiter
    import surfturf_arb_pkg::*;
#(
    parameter int         NSURF      = NSURF_DEFAULT,
    parameter int         TIMEOUT    = 1024,
    parameter logic [7:0] ABORT_BYTE = ABORT_BYTE_DEFAULT
) (
    input  logic               sysclk_i,
    input  logic               sysrst_n_i,
    input  logic [NSURF-1:0]   enable_i,
    input  logic [8*NSURF-1:0] s_tdata,
    input  logic [NSURF-1:0]   s_tvalid,
    input  logic [NSURF-1:0]   s_tlast,
    output logic [NSURF-1:0]   s_tready,
    output logic [7:0]         m_tdata,
    output logic               m_tvalid,
    output logic               m_tlast,
    output logic [IDX_W-1:0]   m_tuser,
    input  logic               m_tready,
    output logic [NSURF-1:0]   timeout_o,
    input  logic [NSURF-1:0]   timeout_clr_i,
    output logic               busy_o,
    output logic [15:0]        pkt_count_o
);

    localparam logic [15:0]      IDLE_LIMIT = 16'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] LAST_INIT  = IDX_W'(NSURF - 1);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] sel_q, sel_d;
    logic [IDX_W-1:0] last_grant_q, last_grant_d;
    logic [15:0]      idle_cnt_q, idle_cnt_d;
    logic [NSURF-1:0] timeout_q, timeout_d;
    logic [15:0]      pkt_count_q, pkt_count_d;

    logic [NSURF-1:0] cand;
    logic [IDX_W-1:0] pick;
    logic             pick_vld;
    logic             sel_vld;
    logic             sel_last;
    logic [7:0]       sel_data;

    assign cand     = s_tvalid & enable_i & ~timeout_q;
    assign sel_vld  = s_tvalid[sel_q];
    assign sel_last = s_tlast[sel_q];
    assign sel_data = s_tdata[int'(sel_q)*8 +: 8];

    surf_rr_pick #(
        .NSURF(NSURF)
    ) u_pick (
        .req       (cand),
        .last_grant(last_grant_q),
        .pick      (pick),
        .pick_vld  (pick_vld)
    );

    always_ff @(posedge sysclk_i or negedge sysrst_n_i) begin
        if (!sysrst_n_i) begin
            state_q      <= IDLE;
            sel_q        <= '0;
            last_grant_q <= LAST_INIT;
            idle_cnt_q   <= '0;
            timeout_q    <= '0;
            pkt_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            last_grant_q <= last_grant_d;
            idle_cnt_q   <= idle_cnt_d;
            timeout_q    <= timeout_d;
            pkt_count_q  <= pkt_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        last_grant_d = last_grant_q;
        idle_cnt_d   = idle_cnt_q;
        // a set below overrides a same-cycle software clear
        timeout_d    = timeout_q & ~timeout_clr_i;
        pkt_count_d  = pkt_count_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    sel_d        = pick;
                    last_grant_d = pick;
                    idle_cnt_d   = '0;
                    state_d      = PASS;
                end
            end
            PASS: begin
                if (sel_vld && m_tready) begin
                    idle_cnt_d = '0;
                    if (sel_last) begin
                        state_d     = IDLE;
                        pkt_count_d = pkt_count_q + 16'd1;
                    end
                end else if (!sel_vld) begin
                    if (idle_cnt_q == IDLE_LIMIT) begin
                        state_d          = ABORT;
                        timeout_d[sel_q] = 1'b1;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 16'd1;
                    end
                end
            end
            ABORT: begin
                if (m_tready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // quarantined sources are drained unless they own the output this cycle
    always_comb begin
        m_tdata  = '0;
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
        m_tuser  = '0;
        s_tready = timeout_q;
        case (state_q)
            PASS: begin
                m_tdata         = sel_data;
                m_tvalid        = sel_vld;
                m_tlast         = sel_last;
                m_tuser         = sel_q;
                s_tready[sel_q] = m_tready;
            end
            ABORT: begin
                m_tdata         = ABORT_BYTE;
                m_tvalid        = 1'b1;
                m_tlast         = 1'b1;
                m_tuser         = sel_q;
                s_tready[sel_q] = 1'b0;
            end
            default: ;
        endcase
    end

    assign timeout_o   = timeout_q;
    assign pkt_count_o = pkt_count_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_surf_event_arbiter.sv
// Directed bench for surf_event_arbiter with a per-source packet model.
module tb_surf_event_arbiter;

    logic        sysclk_i = 1'b0;
    logic        sysrst_n_i = 1'b0;
    logic [6:0]  enable_i;
    logic [55:0] s_tdata;
    logic [6:0]  s_tvalid;
    logic [6:0]  s_tlast;
    logic [6:0]  s_tready;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic [2:0]  m_tuser;
    logic        m_tready;
    logic [6:0]  timeout_o;
    logic [6:0]  timeout_clr_i;
    logic        busy_o;
    logic [15:0] pkt_count_o;

    int n_checks = 0;
    int n_errors = 0;

    int src_pkts[7];
    int src_len[7];
    int src_stall[7];
    int src_beat[7];

    logic [7:0] mon_data[256];
    logic [2:0] mon_user[256];
    logic       mon_last[256];
    int         mon_cyc[256];
    int         mon_n;
    logic [2:0] pk_user[64];
    int         pk_n;
    logic       prev_last;
    int         cyc = 0;

    int t2_exp[6] = '{2, 5, 2, 5, 2, 2};

    always #5 sysclk_i = ~sysclk_i;

    surf_event_arbiter #(
        .NSURF(7),
        .TIMEOUT(16),
        .ABORT_BYTE(8'hFF)
    ) dut (
        .sysclk_i     (sysclk_i),
        .sysrst_n_i   (sysrst_n_i),
        .enable_i     (enable_i),
        .s_tdata      (s_tdata),
        .s_tvalid     (s_tvalid),
        .s_tlast      (s_tlast),
        .s_tready     (s_tready),
        .m_tdata      (m_tdata),
        .m_tvalid     (m_tvalid),
        .m_tlast      (m_tlast),
        .m_tuser      (m_tuser),
        .m_tready     (m_tready),
        .timeout_o    (timeout_o),
        .timeout_clr_i(timeout_clr_i),
        .busy_o       (busy_o),
        .pkt_count_o  (pkt_count_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 7; i++) begin
            s_tvalid[i]       = (src_pkts[i] > 0) && (src_beat[i] < src_stall[i]);
            s_tlast[i]        = (src_beat[i] == src_len[i] - 1);
            s_tdata[8*i +: 8] = 8'(i * 16 + src_beat[i]);
        end
    endtask

    task automatic clr_model();
        for (int i = 0; i < 7; i++) begin
            src_pkts[i]  = 0;
            src_len[i]   = 4;
            src_stall[i] = 100;
            src_beat[i]  = 0;
        end
        enable_i      = '0;
        timeout_clr_i = '0;
        m_tready      = 1'b0;
        drive();
    endtask

    task automatic mon_clear();
        mon_n     = 0;
        pk_n      = 0;
        prev_last = 1'b1;
    endtask

    // sample at negedge, advance the source model after the edge
    task automatic cycle();
        logic [6:0] hs;
        @(negedge sysclk_i);
        hs = s_tvalid & s_tready;
        if (m_tvalid && m_tready) begin
            if (mon_n < 256) begin
                mon_data[mon_n] = m_tdata;
                mon_user[mon_n] = m_tuser;
                mon_last[mon_n] = m_tlast;
                mon_cyc[mon_n]  = cyc;
                mon_n++;
            end
            if (prev_last && pk_n < 64) begin
                pk_user[pk_n] = m_tuser;
                pk_n++;
            end
            prev_last = m_tlast;
        end
        @(posedge sysclk_i);
        #1;
        cyc++;
        for (int i = 0; i < 7; i++) begin
            if (hs[i]) begin
                if (src_beat[i] == src_len[i] - 1) begin
                    src_beat[i] = 0;
                    src_pkts[i]--;
                end else begin
                    src_beat[i]++;
                end
            end
        end
        drive();
    endtask

    task automatic do_reset();
        sysrst_n_i = 1'b0;
        clr_model();
        mon_clear();
        repeat (2) @(posedge sysclk_i);
        #1;
        sysrst_n_i = 1'b1;
    endtask

    task automatic run_until(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (int'(pkt_count_o) < target && n < budget) begin
            cycle();
            n++;
        end
        chk(tag, 32'(pkt_count_o), 32'(target));
    endtask

    initial begin
        int cnt4;
        int mark;
        int n;

        // reset state
        do_reset();
        chk("rst_m_tvalid", 32'(m_tvalid), 0);
        chk("rst_m_tdata", 32'(m_tdata), 0);
        chk("rst_m_tlast", 32'(m_tlast), 0);
        chk("rst_m_tuser", 32'(m_tuser), 0);
        chk("rst_s_tready", 32'(s_tready), 0);
        chk("rst_timeout", 32'(timeout_o), 0);
        chk("rst_pkt_count", 32'(pkt_count_o), 0);
        chk("rst_busy", 32'(busy_o), 0);

        // all seven sources, 4-byte packets
        enable_i = 7'h7F;
        for (int i = 0; i < 7; i++) src_pkts[i] = 1;
        src_pkts[0] = 2;
        m_tready = 1'b1;
        drive();
        run_until(8, 100, "t1_pkts");
        chk("t1_beats", 32'(mon_n), 32);
        for (int k = 0; k < 32; k++) begin
            chk("t1_beat", {mon_user[k], mon_last[k], mon_data[k]},
                {3'((k / 4) % 7), (k % 4) == 3, 8'(((k / 4) % 7) * 16 + k % 4)});
        end
        chk("t1_gap", 32'(mon_cyc[4] - mon_cyc[3]), 2);
        chk("t1_period", 32'(mon_cyc[8] - mon_cyc[4]), 5);

        // sources 2 and 5, enable[5] dropped mid-packet
        do_reset();
        enable_i = 7'b0100100;
        src_pkts[2] = 10; src_len[2] = 3;
        src_pkts[5] = 10; src_len[5] = 3;
        m_tready = 1'b1;
        drive();
        n = 0;
        while (int'(pkt_count_o) < 6 && n < 200) begin
            if (pkt_count_o == 16'd3 && busy_o && m_tuser == 3'd5) enable_i[5] = 1'b0;
            cycle();
            n++;
        end
        chk("t2_pkts", 32'(pkt_count_o), 6);
        chk("t2_starts", 32'(pk_n), 6);
        chk("t2_beats", 32'(mon_n), 18);
        for (int j = 0; j < 6; j++) chk("t2_order", 32'(pk_user[j]), 32'(t2_exp[j]));

        // downstream backpressure toggling, source 3 always valid
        do_reset();
        enable_i = 7'b0001000;
        src_pkts[3] = 2; src_len[3] = 5;
        drive();
        n = 0;
        while (int'(pkt_count_o) < 2 && n < 100) begin
            m_tready = ~m_tready;
            cycle();
            n++;
        end
        chk("t3_pkts", 32'(pkt_count_o), 2);
        chk("t3_beats", 32'(mon_n), 10);
        for (int k = 0; k < 10; k++) begin
            chk("t3_beat", {mon_user[k], mon_last[k], mon_data[k]},
                {3'd3, (k % 5) == 4, 8'(48 + k % 5)});
        end
        chk("t3_timeout", 32'(timeout_o), 0);

        // source 4 stalls after two bytes
        do_reset();
        enable_i = 7'b0010000;
        src_pkts[4] = 1; src_len[4] = 8; src_stall[4] = 2;
        m_tready = 1'b1;
        drive();
        repeat (24) cycle();
        chk("t4_beats", 32'(mon_n), 3);
        chk("t4_beat0", {mon_user[0], mon_last[0], mon_data[0]}, {3'd4, 1'b0, 8'h40});
        chk("t4_beat1", {mon_user[1], mon_last[1], mon_data[1]}, {3'd4, 1'b0, 8'h41});
        chk("t4_abort", {mon_user[2], mon_last[2], mon_data[2]}, {3'd4, 1'b1, 8'hFF});
        chk("t4_abort_gap", 32'(mon_cyc[2] - mon_cyc[1]), 17);
        chk("t4_timeout", 32'(timeout_o), 32'h10);
        chk("t4_pkt_count", 32'(pkt_count_o), 0);
        chk("t4_busy", 32'(busy_o), 0);
        chk("t4_s_tready", 32'(s_tready), 32'h10);

        // quarantined source 4 is never granted until cleared
        mon_clear();
        src_stall[4] = 100; src_pkts[4] = 1000;
        src_pkts[1] = 20; src_len[1] = 2;
        src_pkts[6] = 20; src_len[6] = 2;
        enable_i = 7'h7F;
        drive();
        run_until(4, 100, "t5_pkts");
        cnt4 = 0;
        for (int j = 0; j < pk_n; j++) if (pk_user[j] == 3'd4) cnt4++;
        chk("t5_quarantine", 32'(cnt4), 0);
        chk("t5_sink", 32'(s_tready[4]), 1);
        timeout_clr_i = 7'b0010000;
        cycle();
        timeout_clr_i = '0;
        chk("t5_clear", 32'(timeout_o), 0);
        mark = pk_n;
        run_until(7, 200, "t5_pkts2");
        cnt4 = 0;
        for (int j = mark; j < pk_n; j++) if (pk_user[j] == 3'd4) cnt4++;
        chk("t5_regrant", 32'(cnt4 > 0), 1);

        // asynchronous reset in the middle of a packet
        do_reset();
        enable_i = 7'h7F;
        src_pkts[1] = 1; src_len[1] = 8;
        m_tready = 1'b1;
        drive();
        repeat (3) cycle();
        chk("t6_busy_pre", 32'(busy_o), 1);
        #2;
        sysrst_n_i = 1'b0;
        #1;
        chk("t6_m_tvalid", 32'(m_tvalid), 0);
        chk("t6_m_tdata", 32'(m_tdata), 0);
        chk("t6_m_tlast", 32'(m_tlast), 0);
        chk("t6_m_tuser", 32'(m_tuser), 0);
        chk("t6_s_tready", 32'(s_tready), 0);
        chk("t6_busy", 32'(busy_o), 0);
        chk("t6_pkt_count", 32'(pkt_count_o), 0);
        chk("t6_timeout", 32'(timeout_o), 0);
        clr_model();
        mon_clear();
        enable_i = 7'h7F;
        src_pkts[3] = 1; src_len[3] = 2;
        src_pkts[5] = 1; src_len[5] = 2;
        m_tready = 1'b1;
        drive();
        @(posedge sysclk_i);
        #1;
        sysrst_n_i = 1'b1;
        run_until(1, 50, "t6_pkts");
        chk("t6_first_grant", 32'(pk_user[0]), 3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
